// File: rtl/phase_countdown_timer.sv
// Purpose: seconds countdown timer with 1 s prescaler, load/hold control, expiry pulse and stall detection.
// Latency: load visible on the sampling edge; decrement/tick/expired land on the prescaler wrap edge.
// Backpressure: none; inputs are sampled every cycle and outputs are level/pulse registers.
//
// Ports:
//   clk, rst_n      - system clock, asynchronous active-low reset
//   load_counter    - level load enable (reloads every cycle it is high)
//   load_value[4:0] - seconds to load
//   hold            - freezes prescaler and countdown while high
//   counter_value   - remaining seconds (registered)
//   tick            - one-cycle pulse per second boundary
//   expired         - one-cycle pulse when the count steps 1 -> 0
//   busy            - counter_value != 0
//   stall_fault     - sticky: no reload for STALL_SEC seconds while at zero
module phase_countdown_timer #(
   parameter int unsigned TICKS_PER_SEC = 50_000_000,
   parameter int unsigned STALL_SEC     = 8,
   parameter logic [4:0]  INIT_VALUE    = 5'd0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load_counter,
   input  logic [4:0] load_value,
   input  logic       hold,
   output logic [4:0] counter_value,
   output logic       tick,
   output logic       expired,
   output logic       busy,
   output logic       stall_fault
);

   localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
   localparam int SW = $clog2(STALL_SEC + 1);
   localparam logic [PW-1:0] PRE_MAX   = PW'(TICKS_PER_SEC - 1);
   localparam logic [SW-1:0] STALL_MAX = SW'(STALL_SEC);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [4:0]    cnt_q, cnt_d;
   logic [SW-1:0] stall_q, stall_d;
   logic          tick_q, tick_d;
   logic          exp_q, exp_d;
   logic          fault_q, fault_d;

   logic wrap;
   logic dec;

   // A wrap only happens on a non-held cycle; it still pulses tick when a load
   // coincides, but the load suppresses the decrement.
   assign wrap = !hold && (pre_q == PRE_MAX);
   // Decrement keys off the count rather than the state so that a wrap on the
   // cycle hold drops (state still PAUSED) is not lost.
   assign dec  = wrap && !load_counter && (cnt_q != 5'd0);

   always_comb begin
      pre_d   = pre_q;
      cnt_d   = cnt_q;
      stall_d = stall_q;
      fault_d = fault_q;
      exp_d   = 1'b0;
      tick_d  = wrap;

      if (load_counter) begin
         pre_d = '0;
      end else if (!hold) begin
         pre_d = wrap ? '0 : pre_q + 1'b1;
      end

      if (load_counter) begin
         cnt_d   = load_value;
         stall_d = '0;
         fault_d = 1'b0;
      end else if (dec) begin
         cnt_d = cnt_q - 5'd1;
         exp_d = (cnt_q == 5'd1);
      end else if (wrap && (cnt_q == 5'd0)) begin
         // Idle second without a reload: saturating stall count.
         if (stall_q != STALL_MAX) begin
            stall_d = stall_q + 1'b1;
         end
         if (stall_q >= STALL_MAX - 1'b1) begin
            fault_d = 1'b1;
         end
      end

      if (hold) begin
         state_d = ST_PAUSED;
      end else if (cnt_d != 5'd0) begin
         state_d = ST_RUN;
      end else begin
         state_d = ST_IDLE;
      end

      if ((state_d == ST_RUN) && (state_q != ST_RUN)) begin
         stall_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= (INIT_VALUE != 5'd0) ? ST_RUN : ST_IDLE;
         pre_q   <= '0;
         cnt_q   <= INIT_VALUE;
         stall_q <= '0;
         tick_q  <= 1'b0;
         exp_q   <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         cnt_q   <= cnt_d;
         stall_q <= stall_d;
         tick_q  <= tick_d;
         exp_q   <= exp_d;
         fault_q <= fault_d;
      end
   end

   assign counter_value = cnt_q;
   assign tick          = tick_q;
   assign expired       = exp_q;
   assign stall_fault   = fault_q;
   // Derived straight from the count register so it never lags counter_value.
   assign busy          = (cnt_q != 5'd0);

endmodule

// File: tb/tb_phase_countdown_timer.sv
// Purpose: self-checking bench for phase_countdown_timer (TICKS_PER_SEC=4, STALL_SEC=3).
// Latency: expectations are scheduled per absolute cycle and compared on the falling edge.
// Backpressure: not applicable.
module tb_phase_countdown_timer;

   localparam int K_CNT   = 0;
   localparam int K_TICK  = 1;
   localparam int K_EXP   = 2;
   localparam int K_BUSY  = 3;
   localparam int K_FAULT = 4;

   typedef struct {
      string tag;
      int    cyc;
      int    kind;
      int    val;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       load_counter = 1'b0;
   logic [4:0] load_value = 5'd0;
   logic       hold = 1'b0;
   logic [4:0] counter_value;
   logic       tick;
   logic       expired;
   logic       busy;
   logic       stall_fault;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   phase_countdown_timer #(
      .TICKS_PER_SEC(4),
      .STALL_SEC    (3),
      .INIT_VALUE   (5'd0)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_counter (load_counter),
      .load_value   (load_value),
      .hold         (hold),
      .counter_value(counter_value),
      .tick         (tick),
      .expired      (expired),
      .busy         (busy),
      .stall_fault  (stall_fault)
   );

   task automatic check(input string tag, input integer act, input integer exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic expect_at(input string tag, input int c, input int kind, input int val);
      sb.push_back('{tag, c, kind, val});
   endtask

   function automatic integer observe(input int kind);
      case (kind)
         K_CNT:   return integer'(counter_value);
         K_TICK:  return integer'(tick);
         K_EXP:   return integer'(expired);
         K_BUSY:  return integer'(busy);
         default: return integer'(stall_fault);
      endcase
   endfunction

   // Scoreboard: pop every entry due this cycle; anything overdue is a failure.
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            check(sb[i].tag, observe(sb[i].kind), sb[i].val);
            sb.delete(i);
         end else if (sb[i].cyc < cyc) begin
            check({sb[i].tag, "_missed"}, -1, sb[i].val);
            sb.delete(i);
         end
      end
   end

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic do_load(input logic [4:0] v);
      load_counter = 1'b1;
      load_value   = v;
      @(negedge clk);
      load_counter = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      int l;
      int e;

      // Reset state
      #1;
      check("rst_cnt", counter_value, 0);
      check("rst_busy", busy, 0);
      check("rst_tick", tick, 0);
      check("rst_exp", expired, 0);
      check("rst_fault", stall_fault, 0);
      @(negedge clk);
      @(negedge clk);

      // Idle after reset: stall_fault rises 12 cycles after release
      c = cyc;
      rst_n = 1'b1;
      expect_at("idle_tick4", c + 4, K_TICK, 1);
      expect_at("idle_tick5", c + 5, K_TICK, 0);
      expect_at("idle_cnt", c + 6, K_CNT, 0);
      expect_at("idle_busy", c + 6, K_BUSY, 0);
      expect_at("stall_pre", c + 11, K_FAULT, 0);
      expect_at("stall_rise", c + 12, K_FAULT, 1);
      wait_until(c + 12);
      l = cyc + 1;
      expect_at("stall_clr", l, K_FAULT, 0);
      expect_at("stall_ld5", l, K_CNT, 5);
      do_load(5'd5);
      @(negedge clk);

      // Load 3, plain countdown
      l = cyc + 1;
      for (int k = 0; k < 14; k++) begin
         e = (k < 4) ? 3 : (k < 8) ? 2 : (k < 12) ? 1 : 0;
         expect_at("ld3_cnt", l + k, K_CNT, e);
         expect_at("ld3_busy", l + k, K_BUSY, (e != 0) ? 1 : 0);
         expect_at("ld3_tick", l + k, K_TICK, (k == 4 || k == 8 || k == 12) ? 1 : 0);
         expect_at("ld3_exp", l + k, K_EXP, (k == 12) ? 1 : 0);
      end
      do_load(5'd3);
      wait_until(l + 13);
      @(negedge clk);

      // Load 30 with hold for 10 cycles starting at cycle 2
      l = cyc + 1;
      for (int k = 0; k < 14; k++) begin
         expect_at("hold_cnt", l + k, K_CNT, 30);
         if (k >= 3) expect_at("hold_tick", l + k, K_TICK, 0);
      end
      expect_at("hold_dec", l + 14, K_CNT, 29);
      expect_at("hold_tick14", l + 14, K_TICK, 1);
      do_load(5'd30);
      wait_until(l + 2);
      hold = 1'b1;
      wait_until(l + 12);
      hold = 1'b0;
      wait_until(l + 14);
      @(negedge clk);

      // Reload 3 at value 1, coincident with a wrap
      l = cyc + 1;
      expect_at("co_cnt2", l + 3, K_CNT, 2);
      expect_at("co_cnt1", l + 7, K_CNT, 1);
      do_load(5'd2);
      wait_until(l + 7);
      c = l + 8;
      expect_at("co_cnt", c, K_CNT, 3);
      expect_at("co_tick", c, K_TICK, 1);
      expect_at("co_exp", c, K_EXP, 0);
      expect_at("co_hold3", c + 3, K_CNT, 3);
      expect_at("co_dec", c + 4, K_CNT, 2);
      expect_at("co_tick4", c + 4, K_TICK, 1);
      do_load(5'd3);

      // Load 0 while counting at 2
      wait_until(c + 4);
      l = cyc + 1;
      expect_at("ld0_cnt", l, K_CNT, 0);
      expect_at("ld0_busy", l, K_BUSY, 0);
      for (int k = 0; k < 8; k++) expect_at("ld0_exp", l + k, K_EXP, 0);
      expect_at("ld0_cnt7", l + 7, K_CNT, 0);
      do_load(5'd0);
      wait_until(l + 8);

      // Continuous load holds the value, no tick
      l = cyc + 1;
      for (int k = 0; k < 10; k++) begin
         expect_at("cont_cnt", l + k, K_CNT, 9);
         if (k > 0) expect_at("cont_tick", l + k, K_TICK, 0);
      end
      load_counter = 1'b1;
      load_value   = 5'd9;
      wait_until(l + 9);
      load_counter = 1'b0;
      @(negedge clk);

      // Asynchronous reset mid-count at 17
      l = cyc + 1;
      do_load(5'd17);
      wait_until(l + 2);
      #1;
      check("ar_pre", counter_value, 17);
      rst_n = 1'b0;
      #1;
      check("ar_cnt", counter_value, 0);
      check("ar_busy", busy, 0);
      @(negedge clk);
      c = cyc;
      rst_n = 1'b1;
      expect_at("ar_tick", c + 4, K_TICK, 1);
      expect_at("ar_stay", c + 6, K_CNT, 0);
      wait_until(c + 6);
      l = cyc + 1;
      expect_at("ar_ld", l, K_CNT, 4);
      expect_at("ar_ld_dec", l + 4, K_CNT, 3);
      do_load(5'd4);
      wait_until(l + 5);
      @(negedge clk);

      check("sb_left", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
